instruction_decode_stack: RTL and testbench

- Producer end of the control unit's decode interface.
- Latches the fetched 32-bit instruction word when a fetch strobe arrives, splits it into the fields the control unit and datapath consume (InstructionType, FunctionCode, StopBit, register indices, extended immediate), and holds them stable until the next fetch.
- Owns the return-address stack: JAL pushes, and an instruction with StopBit set pops when that instruction retires.

---
 rtl/instruction_decode_stack.sv | 131 +++++++++++++
 tb/tb_instruction_decode_stack.sv | 370 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_decode_stack.sv
// Instruction latch and field decoder feeding the control unit, plus the
// return-address stack driven by JAL (push) and StopBit (pop) at retirement.
module instruction_decode_stack #(
  parameter int PC_WIDTH    = 32,
  parameter int STACK_DEPTH = 8
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           en_instruction_fetch,
  input  logic [31:0]                    instruction_word,
  input  logic [PC_WIDTH-1:0]            pc_plus_one,
  input  logic                           instruction_done,
  output logic [1:0]                     InstructionType,
  output logic [4:0]                     FunctionCode,
  output logic                           StopBit,
  output logic [3:0]                     rs1,
  output logic [3:0]                     rd,
  output logic [3:0]                     rs2,
  output logic [31:0]                    immediate_ext,
  output logic                           decode_valid,
  output logic [PC_WIDTH-1:0]            return_address,
  output logic                           return_valid,
  output logic [$clog2(STACK_DEPTH):0]   stack_depth,
  output logic                           stack_overflow,
  output logic                           stack_underflow
);

  localparam int PTR_W = $clog2(STACK_DEPTH);
  localparam logic [PTR_W:0] DEPTH_FULL = (PTR_W+1)'(STACK_DEPTH);
  localparam logic [PTR_W:0] DEPTH_ONE  = (PTR_W+1)'(1);

  typedef enum logic [1:0] {
    TYPE_R = 2'b00,
    TYPE_I = 2'b01,
    TYPE_J = 2'b10,
    TYPE_S = 2'b11
  } instr_type_e;

  logic [31:0]         word_q;
  logic [PC_WIDTH-1:0] pc_q;
  logic [PC_WIDTH-1:0] stack_mem [STACK_DEPTH];
  logic [PTR_W:0]      depth_q;
  logic [PTR_W-1:0]    top_idx;
  logic [PTR_W-1:0]    push_idx;
  logic                retire;
  logic                do_push;
  logic                do_pop;
  logic                stack_empty;
  logic                stack_full;

  assign InstructionType = word_q[2:1];
  assign FunctionCode    = word_q[31:27];
  assign StopBit         = word_q[0];
  assign rs1             = word_q[26:23];
  assign rd              = word_q[22:19];
  assign rs2             = word_q[18:15];
  assign stack_depth     = depth_q;

  assign retire      = instruction_done & decode_valid;
  assign do_push     = retire & (instr_type_e'(word_q[2:1]) == TYPE_J) & (word_q[31:27] == 5'd1);
  assign do_pop      = retire & word_q[0];
  assign stack_empty = (depth_q == '0);
  assign stack_full  = (depth_q == DEPTH_FULL);
  assign push_idx    = depth_q[PTR_W-1:0];
  assign top_idx     = depth_q[PTR_W-1:0] + {PTR_W{1'b1}};

  always_comb begin
    immediate_ext = 32'd0;
    case (instr_type_e'(word_q[2:1]))
      TYPE_I:  immediate_ext = {{16{word_q[18]}}, word_q[18:3]};
      TYPE_J:  immediate_ext = {{8{word_q[26]}}, word_q[26:3]};
      TYPE_S:  immediate_ext = {27'd0, word_q[18:14]};
      default: immediate_ext = 32'd0;
    endcase
  end

  // Entry storage is not reset; only the pointer defines what is live.
  // A push that coincides with a pop on a non-empty stack overwrites the top.
  always_ff @(posedge clock) begin
    if (do_push) begin
      if (do_pop && !stack_empty) begin
        stack_mem[top_idx] <= pc_q;
      end else if (!stack_full) begin
        stack_mem[push_idx] <= pc_q;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      word_q          <= '0;
      pc_q            <= '0;
      decode_valid    <= 1'b0;
      depth_q         <= '0;
      return_address  <= '0;
      return_valid    <= 1'b0;
      stack_overflow  <= 1'b0;
      stack_underflow <= 1'b0;
    end else begin
      return_valid <= 1'b0;
      if (en_instruction_fetch) begin
        word_q       <= instruction_word;
        pc_q         <= pc_plus_one;
        decode_valid <= 1'b1;
      end
      // Retire always acts on the previously latched word, even on a fetch edge.
      if (do_pop) begin
        return_valid <= 1'b1;
        if (stack_empty) begin
          return_address  <= '0;
          stack_underflow <= 1'b1;
          if (do_push) begin
            depth_q <= DEPTH_ONE;
          end
        end else begin
          return_address <= stack_mem[top_idx];
          if (!do_push) begin
            depth_q <= depth_q - DEPTH_ONE;
          end
        end
      end else if (do_push) begin
        if (stack_full) begin
          stack_overflow <= 1'b1;
        end else begin
          depth_q <= depth_q + DEPTH_ONE;
        end
      end
    end
  end

endmodule

// File: tb/tb_instruction_decode_stack.sv
// Self-checking bench for instruction_decode_stack: decode fields, immediates,
// and a queue-based model of the return-address stack as a scoreboard.
module tb_instruction_decode_stack;

  logic        clock;
  logic        reset;
  logic        en_instruction_fetch;
  logic [31:0] instruction_word;
  logic [31:0] pc_plus_one;
  logic        instruction_done;
  logic [1:0]  InstructionType;
  logic [4:0]  FunctionCode;
  logic        StopBit;
  logic [3:0]  rs1;
  logic [3:0]  rd;
  logic [3:0]  rs2;
  logic [31:0] immediate_ext;
  logic        decode_valid;
  logic [31:0] return_address;
  logic        return_valid;
  logic [3:0]  stack_depth;
  logic        stack_overflow;
  logic        stack_underflow;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [31:0] cur_word;
  logic [31:0] cur_pc;
  bit          model_valid;
  logic [31:0] model_stk[$];
  logic [31:0] exp_q[$];
  logic [31:0] mon_exp;

  instruction_decode_stack #(.PC_WIDTH(32), .STACK_DEPTH(8)) dut (
    .clock(clock), .reset(reset),
    .en_instruction_fetch(en_instruction_fetch),
    .instruction_word(instruction_word), .pc_plus_one(pc_plus_one),
    .instruction_done(instruction_done),
    .InstructionType(InstructionType), .FunctionCode(FunctionCode),
    .StopBit(StopBit), .rs1(rs1), .rd(rd), .rs2(rs2),
    .immediate_ext(immediate_ext), .decode_valid(decode_valid),
    .return_address(return_address), .return_valid(return_valid),
    .stack_depth(stack_depth), .stack_overflow(stack_overflow),
    .stack_underflow(stack_underflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Scoreboard consumer: every return_valid pulse must match the oldest expectation.
  always @(negedge clock) begin
    if (!reset && return_valid) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("[TB] FAIL unexpected_return_valid: got return_address=%h, no pop expected", return_address);
      end else begin
        mon_exp = exp_q.pop_front();
        if (return_address !== mon_exp) begin
          n_fail++;
          $display("[TB] FAIL return_address: got %h expected %h", return_address, mon_exp);
        end
      end
    end
  end

  task automatic model_retire();
    bit push, pop;
    push = (cur_word[2:1] == 2'b10) && (cur_word[31:27] == 5'd1);
    pop  = cur_word[0];
    if (push && pop) begin
      if (model_stk.size() > 0) begin
        exp_q.push_back(model_stk[$]);
        model_stk[$] = cur_pc;
      end else begin
        exp_q.push_back(32'd0);
        model_stk.push_back(cur_pc);
      end
    end else if (push) begin
      if (model_stk.size() < 8) model_stk.push_back(cur_pc);
    end else if (pop) begin
      if (model_stk.size() > 0) exp_q.push_back(model_stk.pop_back());
      else exp_q.push_back(32'd0);
    end
  endtask

  task automatic drive_cycle(input bit fetch, input logic [31:0] word,
                             input logic [31:0] pc, input bit done);
    @(negedge clock);
    en_instruction_fetch = fetch;
    instruction_word     = word;
    pc_plus_one          = pc;
    instruction_done     = done;
    if (done && model_valid) model_retire();
    if (fetch) begin
      cur_word    = word;
      cur_pc      = pc;
      model_valid = 1'b1;
    end
    @(posedge clock);
    #1;
    en_instruction_fetch = 1'b0;
    instruction_done     = 1'b0;
  endtask

  task automatic assert_reset();
    @(negedge clock);
    #2 reset = 1'b1;
    #1;
    model_stk.delete();
    exp_q.delete();
    model_valid = 1'b0;
    cur_word    = '0;
    cur_pc      = '0;
  endtask

  task automatic release_reset();
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic settle();
    @(negedge clock);
    #1;
  endtask

  task automatic test_reset();
    assert_reset();
    n_cmp++;
    if ({InstructionType, FunctionCode, StopBit, rs1, rd, rs2, immediate_ext, decode_valid,
         return_address, return_valid, stack_depth, stack_overflow, stack_underflow} !== '0) begin
      n_fail++;
      $display("[TB] FAIL reset_outputs: got type=%b fc=%h imm=%h dv=%b ra=%h rv=%b depth=%0d ovf=%b unf=%b expected all zero",
               InstructionType, FunctionCode, immediate_ext, decode_valid, return_address,
               return_valid, stack_depth, stack_overflow, stack_underflow);
    end
    release_reset();
  endtask

  task automatic test_decode_fields();
    drive_cycle(1'b1, 32'h0888_8002, 32'h4, 1'b0);
    n_cmp++;
    if ({InstructionType, FunctionCode, rs1, rd, decode_valid} !== {2'b01, 5'd1, 4'd1, 4'd1, 1'b1}) begin
      n_fail++;
      $display("[TB] FAIL addi_fields: got type=%b fc=%0d rs1=%0d rd=%0d dv=%b expected 01/1/1/1/1",
               InstructionType, FunctionCode, rs1, rd, decode_valid);
    end
    // bits [18:3] of 0x0888_8002 are 0x1000
    n_cmp++;
    if (immediate_ext !== 32'h0000_1000) begin
      n_fail++;
      $display("[TB] FAIL addi_imm: got %h expected 00001000", immediate_ext);
    end
    drive_cycle(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    n_cmp++;
    if ({InstructionType, immediate_ext} !== {2'b01, 32'h0000_1000}) begin
      n_fail++;
      $display("[TB] FAIL hold_without_fetch: got type=%b imm=%h expected 01/00001000",
               InstructionType, immediate_ext);
    end
  endtask

  task automatic test_immediates();
    logic [31:0] words [5] = '{32'h0007_FFFA, 32'h0003_FFFA, 32'h0400_0004, 32'h0007_C006, 32'hFFFF_FFF9};
    logic [31:0] imms  [5] = '{32'hFFFF_FFFF, 32'h0000_7FFF, 32'hFF80_0000, 32'h0000_001F, 32'h0000_0000};
    logic [1:0]  types [5] = '{2'b01, 2'b01, 2'b10, 2'b11, 2'b00};
    for (int i = 0; i < 5; i++) begin
      drive_cycle(1'b1, words[i], 32'h8, 1'b0);
      n_cmp++;
      if ({InstructionType, immediate_ext} !== {types[i], imms[i]}) begin
        n_fail++;
        $display("[TB] FAIL imm_%0d: got type=%b imm=%h expected type=%b imm=%h",
                 i, InstructionType, immediate_ext, types[i], imms[i]);
      end
    end
    n_cmp++;
    if ({StopBit, rs2, FunctionCode} !== {1'b1, 4'hF, 5'h1F}) begin
      n_fail++;
      $display("[TB] FAIL r_fields: got stop=%b rs2=%h fc=%h expected 1/f/1f", StopBit, rs2, FunctionCode);
    end
  endtask

  task automatic test_push_pop();
    assert_reset();
    release_reset();
    drive_cycle(1'b1, 32'h0800_0004, 32'h10, 1'b0);
    drive_cycle(1'b0, 32'h0, 32'h0, 1'b1);
    n_cmp++;
    if (stack_depth !== 4'd1) begin
      n_fail++;
      $display("[TB] FAIL jal_push_depth: got %0d expected 1", stack_depth);
    end
    drive_cycle(1'b1, 32'h0000_0001, 32'h11, 1'b0);
    drive_cycle(1'b0, 32'h0, 32'h0, 1'b1);
    n_cmp++;
    if ({return_valid, stack_depth} !== {1'b1, 4'd0}) begin
      n_fail++;
      $display("[TB] FAIL pop_pulse: got rv=%b depth=%0d expected 1/0", return_valid, stack_depth);
    end
    settle();
    settle();
    n_cmp++;
    if ({return_valid, return_address, exp_q.size() == 0} !== {1'b0, 32'h10, 1'b1}) begin
      n_fail++;
      $display("[TB] FAIL pop_one_cycle: got rv=%b ra=%h pending=%0d expected 0/00000010/0",
               return_valid, return_address, exp_q.size());
    end
    drive_cycle(1'b1, 32'h0800_0004, 32'h30, 1'b0);
    drive_cycle(1'b0, 32'h0, 32'h0, 1'b1);
    drive_cycle(1'b1, 32'h0800_0004, 32'h40, 1'b0);
    drive_cycle(1'b0, 32'h0, 32'h0, 1'b1);
    drive_cycle(1'b1, 32'h0000_0001, 32'h41, 1'b0);
    drive_cycle(1'b0, 32'h0, 32'h0, 1'b1);
    drive_cycle(1'b0, 32'h0, 32'h0, 1'b1);
    settle();
    settle();
    n_cmp++;
    if ({stack_depth, stack_underflow, exp_q.size() == 0} !== {4'd0, 1'b0, 1'b1}) begin
      n_fail++;
      $display("[TB] FAIL lifo_drain: got depth=%0d unf=%b pending=%0d expected 0/0/0",
               stack_depth, stack_underflow, exp_q.size());
    end
  endtask

  task automatic test_push_and_pop();
    drive_cycle(1'b1, 32'h0800_0004, 32'h10, 1'b0);
    drive_cycle(1'b0, 32'h0, 32'h0, 1'b1);
    drive_cycle(1'b1, 32'h0800_0005, 32'h60, 1'b0);
    drive_cycle(1'b0, 32'h0, 32'h0, 1'b1);
    n_cmp++;
    if ({return_valid, stack_depth} !== {1'b1, 4'd1}) begin
      n_fail++;
      $display("[TB] FAIL swap_top: got rv=%b depth=%0d expected 1/1", return_valid, stack_depth);
    end
    drive_cycle(1'b1, 32'h0000_0001, 32'h61, 1'b0);
    drive_cycle(1'b0, 32'h0, 32'h0, 1'b1);
    drive_cycle(1'b1, 32'h0800_0005, 32'h70, 1'b0);
    drive_cycle(1'b0, 32'h0, 32'h0, 1'b1);
    n_cmp++;
    if ({stack_depth, stack_underflow, stack_overflow} !== {4'd1, 1'b1, 1'b0}) begin
      n_fail++;
      $display("[TB] FAIL swap_empty: got depth=%0d unf=%b ovf=%b expected 1/1/0",
               stack_depth, stack_underflow, stack_overflow);
    end
    settle();
    settle();
  endtask

  task automatic test_overflow();
    assert_reset();
    release_reset();
    drive_cycle(1'b1, 32'h0800_0004, 32'h100, 1'b0);
    for (int i = 0; i < 8; i++) drive_cycle(1'b0, 32'h0, 32'h0, 1'b1);
    n_cmp++;
    if ({stack_depth, stack_overflow} !== {4'd8, 1'b0}) begin
      n_fail++;
      $display("[TB] FAIL full_no_ovf: got depth=%0d ovf=%b expected 8/0", stack_depth, stack_overflow);
    end
    drive_cycle(1'b0, 32'h0, 32'h0, 1'b1);
    n_cmp++;
    if ({stack_depth, stack_overflow} !== {4'd8, 1'b1}) begin
      n_fail++;
      $display("[TB] FAIL overflow: got depth=%0d ovf=%b expected 8/1", stack_depth, stack_overflow);
    end
    drive_cycle(1'b1, 32'h0000_0001, 32'h101, 1'b0);
    drive_cycle(1'b0, 32'h0, 32'h0, 1'b1);
    settle();
    n_cmp++;
    if ({stack_depth, stack_overflow} !== {4'd7, 1'b1}) begin
      n_fail++;
      $display("[TB] FAIL pop_after_full: got depth=%0d ovf=%b expected 7/1", stack_depth, stack_overflow);
    end
  endtask

  task automatic test_underflow();
    assert_reset();
    release_reset();
    drive_cycle(1'b1, 32'h0000_0001, 32'h5, 1'b0);
    drive_cycle(1'b0, 32'h0, 32'h0, 1'b1);
    n_cmp++;
    if ({return_valid, return_address, stack_depth, stack_underflow, stack_overflow} !==
        {1'b1, 32'h0, 4'd0, 1'b1, 1'b0}) begin
      n_fail++;
      $display("[TB] FAIL underflow: got rv=%b ra=%h depth=%0d unf=%b ovf=%b expected 1/0/0/1/0",
               return_valid, return_address, stack_depth, stack_underflow, stack_overflow);
    end
    settle();
  endtask

  task automatic test_back_to_back();
    assert_reset();
    release_reset();
    drive_cycle(1'b1, 32'h0800_0004, 32'h20, 1'b0);
    drive_cycle(1'b1, 32'h0007_C006, 32'h21, 1'b1);
    n_cmp++;
    if ({stack_depth, InstructionType, immediate_ext} !== {4'd1, 2'b11, 32'h1F}) begin
      n_fail++;
      $display("[TB] FAIL same_edge: got depth=%0d type=%b imm=%h expected 1/11/0000001f",
               stack_depth, InstructionType, immediate_ext);
    end
    drive_cycle(1'b1, 32'h0000_0001, 32'h22, 1'b0);
    drive_cycle(1'b0, 32'h0, 32'h0, 1'b1);
    settle();
    settle();
    n_cmp++;
    if ({return_address, exp_q.size() == 0} !== {32'h20, 1'b1}) begin
      n_fail++;
      $display("[TB] FAIL same_edge_pop: got ra=%h pending=%0d expected 00000020/0",
               return_address, exp_q.size());
    end
  endtask

  task automatic test_reset_mid_op();
    drive_cycle(1'b1, 32'h0800_0004, 32'h30, 1'b0);
    drive_cycle(1'b0, 32'h0, 32'h0, 1'b1);
    drive_cycle(1'b0, 32'h0, 32'h0, 1'b1);
    drive_cycle(1'b1, 32'h0000_0001, 32'h31, 1'b0);
    drive_cycle(1'b0, 32'h0, 32'h0, 1'b1);
    #1 reset = 1'b1;
    #1;
    model_stk.delete();
    exp_q.delete();
    model_valid = 1'b0;
    n_cmp++;
    if ({stack_depth, return_valid, stack_overflow, stack_underflow, decode_valid} !== '0) begin
      n_fail++;
      $display("[TB] FAIL reset_mid_op: got depth=%0d rv=%b ovf=%b unf=%b dv=%b expected all 0",
               stack_depth, return_valid, stack_overflow, stack_underflow, decode_valid);
    end
    release_reset();
    drive_cycle(1'b0, 32'h0800_0004, 32'h40, 1'b1);
    n_cmp++;
    if ({stack_depth, return_valid, decode_valid} !== '0) begin
      n_fail++;
      $display("[TB] FAIL done_before_fetch: got depth=%0d rv=%b dv=%b expected 0/0/0",
               stack_depth, return_valid, decode_valid);
    end
  endtask

  initial begin
    reset                = 1'b1;
    en_instruction_fetch = 1'b0;
    instruction_word     = '0;
    pc_plus_one          = '0;
    instruction_done     = 1'b0;
    cur_word             = '0;
    cur_pc               = '0;
    model_valid          = 1'b0;
    test_reset();
    test_decode_fields();
    test_immediates();
    test_push_pop();
    test_push_and_pop();
    test_overflow();
    test_underflow();
    test_back_to_back();
    test_reset_mid_op();
    settle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
